// File: rtl/cluster_issue_scheduler.sv
// Cluster issue scheduler: requests instruction clusters from the cluster
// generator, captures them, and drains the valid slots to the dispatch stage
// up to ISSUE_WIDTH per cycle in ascending slot order.
module cluster_issue_scheduler #(
  parameter int CLUSTER_SIZE = 32,
  parameter int ISSUE_WIDTH  = 4,
  parameter int PC_WIDTH     = 32,
  parameter int INST_WIDTH   = 16,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run_enable,
  input  logic                               flush_pipeline,
  output logic                               fetch_enable,
  input  logic                               cl_valid,
  input  logic [CLUSTER_SIZE-1:0]            cl_mask,
  input  logic [PC_WIDTH*CLUSTER_SIZE-1:0]   cl_pc,
  input  logic [INST_WIDTH*CLUSTER_SIZE-1:0] cl_inst,
  output logic [ISSUE_WIDTH-1:0]             iss_valid,
  output logic [PC_WIDTH*ISSUE_WIDTH-1:0]    iss_pc,
  output logic [INST_WIDTH*ISSUE_WIDTH-1:0]  iss_inst,
  input  logic                               iss_ready,
  output logic                               busy,
  output logic [$clog2(CLUSTER_SIZE):0]      issued_count
);

  localparam int CNT_W  = $clog2(CLUSTER_SIZE) + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int LANE_W = $clog2(ISSUE_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic [CLUSTER_SIZE-1:0]           rem_q, rem_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [WAIT_W-1:0]                 wait_q, wait_d;
  logic [PC_WIDTH*CLUSTER_SIZE-1:0]  pc_q;
  logic [INST_WIDTH*CLUSTER_SIZE-1:0] inst_q;
  logic                              capture;

  logic [ISSUE_WIDTH-1:0]            laneValid;
  logic [PC_WIDTH*ISSUE_WIDTH-1:0]   lanePc;
  logic [INST_WIDTH*ISSUE_WIDTH-1:0] laneInst;
  logic [CLUSTER_SIZE-1:0]           selMask;
  logic [LANE_W-1:0]                 laneCount;
  logic [SUM_W-1:0]                  cntSum;
  logic [CLUSTER_SIZE-1:0]           remAfter;
  logic                              issueActive;
  logic                              handshake;

  // Pick the lowest-index ISSUE_WIDTH remaining slots and pack them from lane 0
  always_comb begin
    int lane;
    lane      = 0;
    laneValid = '0;
    lanePc    = '0;
    laneInst  = '0;
    selMask   = '0;
    for (int i = 0; i < CLUSTER_SIZE; i++) begin
      if (rem_q[i] && (lane < ISSUE_WIDTH)) begin
        laneValid[lane]                          = 1'b1;
        lanePc[lane*PC_WIDTH +: PC_WIDTH]        = pc_q[i*PC_WIDTH +: PC_WIDTH];
        laneInst[lane*INST_WIDTH +: INST_WIDTH]  = inst_q[i*INST_WIDTH +: INST_WIDTH];
        selMask[i]                               = 1'b1;
        lane                                     = lane + 1;
      end
    end
    laneCount = LANE_W'(lane);
  end

  // Flush suppresses issue and request outputs in the very cycle it is seen
  assign issueActive  = (state_q == S_ISSUE) && !flush_pipeline;
  assign handshake    = issueActive && (|laneValid) && iss_ready;
  assign iss_valid    = issueActive ? laneValid : '0;
  assign iss_pc       = issueActive ? lanePc : '0;
  assign iss_inst     = issueActive ? laneInst : '0;
  assign fetch_enable = (state_q == S_REQ) && !flush_pipeline;
  assign busy         = (state_q != S_IDLE);
  assign issued_count = cnt_q;
  assign cntSum       = {1'b0, cnt_q} + SUM_W'(laneCount);
  assign remAfter     = rem_q & ~selMask;

  // Sequencing: request, wait (with re-request timeout), capture, drain
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    capture = 1'b0;
    if (flush_pipeline) begin
      state_d = S_IDLE;
      rem_d   = '0;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_enable) state_d = S_REQ;
        end
        S_REQ: begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
        S_WAIT: begin
          if (cl_valid) begin
            capture = 1'b1;
            rem_d   = cl_mask;
            cnt_d   = '0;
            if (|cl_mask) state_d = S_ISSUE;
            else          state_d = run_enable ? S_REQ : S_IDLE;
          end else if (wait_q == WAIT_W'(WAIT_TIMEOUT - 1)) begin
            state_d = S_REQ;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            rem_d = remAfter;
            cnt_d = (cntSum > SUM_W'(CLUSTER_SIZE)) ? CNT_W'(CLUSTER_SIZE)
                                                    : cntSum[CNT_W-1:0];
            if (remAfter == '0) state_d = run_enable ? S_REQ : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Cluster payload buffers, loaded only on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      inst_q <= '0;
    end else if (capture) begin
      pc_q   <= cl_pc;
      inst_q <= cl_inst;
    end
  end

endmodule
